// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan code decoder: folds E0/F0 prefixes into key events held in a FWFT FIFO.
// Define ASCII_LUT_EN to add a per-event ascii output with shift tracking.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       clock_fpga,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       new_code,
  input  logic       rd_en,
  output logic [7:0] event_code,
  output logic       event_ext,
  output logic       event_rel,
`ifdef ASCII_LUT_EN
  output logic [7:0] ascii,
`endif
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef ASCII_LUT_EN
  localparam int EW = 18;
`else
  localparam int EW = 10;
`endif

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          state, next_state;
  logic            new_code_d, byte_stb, load_timer;
  logic [7:0]      code_byte;
  logic [TW-1:0]   timer;
  logic            push, push_ext, push_rel, do_push, pop;
  logic [AW-1:0]   wr_ptr, rd_ptr, next_rd;
  logic [CW-1:0]   count, next_count;
  logic [EW-1:0]   push_entry, head, head_next;
  logic [EW-1:0]   mem [FIFO_DEPTH];

  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_discard = 1'b1;
      default:                                  is_discard = 1'b0;
    endcase
  endfunction

  // Edge detect on new_code; tracking during reset suppresses a strobe for a level already high.
  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      new_code_d <= new_code;
      byte_stb   <= 1'b0;
      code_byte  <= 8'h00;
    end else begin
      new_code_d <= new_code;
      byte_stb   <= new_code & ~new_code_d;
      code_byte  <= data_in;
    end
  end

  // Prefix FSM state register
  always_ff @(posedge clock_fpga) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Prefix FSM next state and event push decode
  always_comb begin
    next_state = state;
    push       = 1'b0;
    push_ext   = 1'b0;
    push_rel   = 1'b0;
    load_timer = 1'b0;
    if (byte_stb) begin
      case (state)
        IDLE: begin
          if (code_byte == 8'hE0) begin
            next_state = EXT;
            load_timer = 1'b1;
          end else if (code_byte == 8'hF0) begin
            next_state = BRK;
            load_timer = 1'b1;
          end else if (is_discard(code_byte)) begin
            next_state = IDLE;
          end else begin
            push = 1'b1;
          end
        end
        EXT: begin
          load_timer = (code_byte == 8'hE0) || (code_byte == 8'hF0);
          if (code_byte == 8'hF0)      next_state = EXT_BRK;
          else if (code_byte == 8'hE0) next_state = EXT;
          else begin
            next_state = IDLE;
            push       = 1'b1;
            push_ext   = 1'b1;
          end
        end
        BRK, EXT_BRK: begin
          next_state = IDLE;
          if (code_byte != 8'hE0 && code_byte != 8'hF0) begin
            push     = 1'b1;
            push_ext = (state == EXT_BRK);
            push_rel = 1'b1;
          end else begin
            push = 1'b0;
          end
        end
        default: next_state = IDLE;
      endcase
    end else if (state != IDLE && timer == {TW{1'b0}}) begin
      next_state = IDLE;
    end else begin
      next_state = state;
    end
  end

  // Prefix timeout counter; reloaded whenever a prefix state is entered
  always_ff @(posedge clock_fpga) begin
    if (reset)                                     timer <= {TW{1'b0}};
    else if (load_timer)                           timer <= TW'(TIMEOUT_CYC);
    else if (state != IDLE && timer != {TW{1'b0}}) timer <= timer - 1'b1;
    else                                           timer <= timer;
  end

`ifdef ASCII_LUT_EN
  logic shift;

  function automatic logic [7:0] ascii_lut(input logic [7:0] c, input logic sh);
    logic [7:0] lc;
    case (c)
      8'h1C: lc = 8'h61; 8'h32: lc = 8'h62; 8'h21: lc = 8'h63; 8'h23: lc = 8'h64;
      8'h24: lc = 8'h65; 8'h2B: lc = 8'h66; 8'h34: lc = 8'h67; 8'h33: lc = 8'h68;
      8'h43: lc = 8'h69; 8'h3B: lc = 8'h6A; 8'h42: lc = 8'h6B; 8'h4B: lc = 8'h6C;
      8'h3A: lc = 8'h6D; 8'h31: lc = 8'h6E; 8'h44: lc = 8'h6F; 8'h4D: lc = 8'h70;
      8'h15: lc = 8'h71; 8'h2D: lc = 8'h72; 8'h1B: lc = 8'h73; 8'h2C: lc = 8'h74;
      8'h3C: lc = 8'h75; 8'h2A: lc = 8'h76; 8'h1D: lc = 8'h77; 8'h22: lc = 8'h78;
      8'h35: lc = 8'h79; 8'h1A: lc = 8'h7A;
      8'h45: lc = 8'h30; 8'h16: lc = 8'h31; 8'h1E: lc = 8'h32; 8'h26: lc = 8'h33;
      8'h25: lc = 8'h34; 8'h2E: lc = 8'h35; 8'h36: lc = 8'h36; 8'h3D: lc = 8'h37;
      8'h3E: lc = 8'h38; 8'h46: lc = 8'h39;
      8'h29: lc = 8'h20; 8'h5A: lc = 8'h0D;
      default: lc = 8'h00;
    endcase
    if (sh && lc >= 8'h61 && lc <= 8'h7A) ascii_lut = lc - 8'h20;
    else                                  ascii_lut = lc;
  endfunction

  // Shift key state follows decoded L/R-shift make and release events
  always_ff @(posedge clock_fpga) begin
    if (reset) shift <= 1'b0;
    else if (push && !push_ext && (code_byte == 8'h12 || code_byte == 8'h59)) shift <= ~push_rel;
    else shift <= shift;
  end

  assign push_entry = {(push_ext || push_rel) ? 8'h00 : ascii_lut(code_byte, shift),
                       code_byte, push_ext, push_rel};
  assign ascii      = head[17:10];
`else
  assign push_entry = {code_byte, push_ext, push_rel};
`endif

  assign event_code = head[9:2];
  assign event_ext  = head[1];
  assign event_rel  = head[0];

  // FIFO control and next-head lookahead; a push into an empty slot at the read pointer bypasses mem
  always_comb begin
    pop     = rd_en & ~empty;
    do_push = push & (~full | pop);
    next_rd = pop ? rd_ptr + 1'b1 : rd_ptr;
    case ({do_push, pop})
      2'b10:   next_count = count + 1'b1;
      2'b01:   next_count = count - 1'b1;
      default: next_count = count;
    endcase
    if (do_push && (wr_ptr == next_rd)) head_next = push_entry;
    else                                head_next = mem[next_rd];
  end

  // FIFO storage
  always_ff @(posedge clock_fpga) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers, registered status flags and head outputs
  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      wr_ptr   <= {AW{1'b0}};
      rd_ptr   <= {AW{1'b0}};
      count    <= {CW{1'b0}};
      head     <= {EW{1'b0}};
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= next_rd;
      count  <= next_count;
      empty  <= (next_count == {CW{1'b0}});
      full   <= (next_count == CW'(FIFO_DEPTH));
      if (next_count != {CW{1'b0}}) head <= head_next;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder (FIFO_DEPTH=4, TIMEOUT_CYC=100).
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset, new_code, rd_en;
  logic [7:0] data_in;
  logic [7:0] event_code;
  logic       event_ext, event_rel, empty, full, overflow;
`ifdef ASCII_LUT_EN
  logic [7:0] ascii;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYC(100)) dut (
    .clock_fpga(clk), .reset(reset), .data_in(data_in), .new_code(new_code),
    .rd_en(rd_en), .event_code(event_code), .event_ext(event_ext),
    .event_rel(event_rel),
`ifdef ASCII_LUT_EN
    .ascii(ascii),
`endif
    .empty(empty), .full(full), .overflow(overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // new_code held high 20 cycles; optional rd_en on the push edge
  task automatic send_byte(input logic [7:0] b, input bit pop_on_push);
    @(negedge clk);
    data_in  = b;
    new_code = 1'b1;
    @(negedge clk);
    if (pop_on_push) rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    repeat (18) @(negedge clk);
    new_code = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_head(input string tag, input logic [7:0] c, input logic e, input logic r);
    check_eq({tag, "_empty"}, {31'd0, empty}, 32'd0);
    check_eq({tag, "_code"}, {24'd0, event_code}, {24'd0, c});
    check_eq({tag, "_ext"}, {31'd0, event_ext}, {31'd0, e});
    check_eq({tag, "_rel"}, {31'd0, event_rel}, {31'd0, r});
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; new_code = 1'b1; rd_en = 1'b0; data_in = 8'h1C;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // new_code already high across reset release: no strobe, so nothing queued
    repeat (5) @(negedge clk);
    check_eq("rst_empty", {31'd0, empty}, 32'd1);
    check_eq("rst_full", {31'd0, full}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    check_eq("rst_code", {24'd0, event_code}, 32'd0);
    check_eq("rst_ext", {31'd0, event_ext}, 32'd0);
    check_eq("rst_rel", {31'd0, event_rel}, 32'd0);
    new_code = 1'b0;
    repeat (3) @(negedge clk);

    // Latency: empty falls on the 2nd edge after new_code is sampled high
    data_in = 8'h1C; new_code = 1'b1;
    @(negedge clk);
    check_eq("lat_edge1", {31'd0, empty}, 32'd1);
    @(negedge clk);
    check_eq("lat_edge2", {31'd0, empty}, 32'd0);
    repeat (18) @(negedge clk);
    new_code = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    check_head("make", 8'h1C, 1'b0, 1'b0);
    pop_one();
    check_head("brk", 8'h1C, 1'b0, 1'b1);
    pop_one();
    check_eq("two_push_empty", {31'd0, empty}, 32'd1);
    check_eq("hold_code", {24'd0, event_code}, 32'h1C);

    // Extended make and break
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
    check_head("ext_make", 8'h75, 1'b1, 1'b0);
    pop_one();
    check_head("ext_brk", 8'h75, 1'b1, 1'b1);
    pop_one();
    check_eq("ext_empty", {31'd0, empty}, 32'd1);

    // Prefix timeout
    send_byte(8'hE0, 1'b0);
    repeat (120) @(negedge clk);
    check_eq("tmo_nopush", {31'd0, empty}, 32'd1);
    send_byte(8'h1C, 1'b0);
    check_head("tmo", 8'h1C, 1'b0, 1'b0);
    pop_one();

    // Discarded bytes and BRK protocol error
    send_byte(8'hAA, 1'b0); send_byte(8'hFA, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'hE0, 1'b0);
    check_eq("discard_empty", {31'd0, empty}, 32'd1);
    send_byte(8'h29, 1'b0);
    check_head("after_err", 8'h29, 1'b0, 1'b0);
    pop_one();

    // Full with simultaneous push and pop
    send_byte(8'h15, 1'b0); send_byte(8'h1D, 1'b0);
    send_byte(8'h24, 1'b0); send_byte(8'h2D, 1'b0);
    check_eq("full4", {31'd0, full}, 32'd1);
    send_byte(8'h2C, 1'b1);
    check_eq("pp_full", {31'd0, full}, 32'd1);
    check_eq("pp_ovf", {31'd0, overflow}, 32'd0);
    check_head("pp_h0", 8'h1D, 1'b0, 1'b0); pop_one();
    check_head("pp_h1", 8'h24, 1'b0, 1'b0); pop_one();
    check_head("pp_h2", 8'h2D, 1'b0, 1'b0); pop_one();
    check_head("pp_h3", 8'h2C, 1'b0, 1'b0); pop_one();
    check_eq("pp_empty", {31'd0, empty}, 32'd1);

    // Overflow: six makes, only the first four kept
    send_byte(8'h15, 1'b0); send_byte(8'h1D, 1'b0); send_byte(8'h24, 1'b0);
    send_byte(8'h2D, 1'b0);
    check_eq("of_noovf_yet", {31'd0, overflow}, 32'd0);
    send_byte(8'h2C, 1'b0); send_byte(8'h35, 1'b0);
    check_eq("of_full", {31'd0, full}, 32'd1);
    check_eq("of_ovf", {31'd0, overflow}, 32'd1);
    check_head("of_h0", 8'h15, 1'b0, 1'b0); pop_one();
    check_eq("of_notfull", {31'd0, full}, 32'd0);
    check_head("of_h1", 8'h1D, 1'b0, 1'b0); pop_one();
    check_head("of_h2", 8'h24, 1'b0, 1'b0); pop_one();
    check_head("of_h3", 8'h2D, 1'b0, 1'b0); pop_one();
    check_eq("of_empty", {31'd0, empty}, 32'd1);
    pop_one();
    check_eq("of_pop_empty", {31'd0, empty}, 32'd1);
    check_eq("of_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-sequence discards the E0 prefix
    send_byte(8'hE0, 1'b0);
    do_reset();
    check_eq("rst2_ovf", {31'd0, overflow}, 32'd0);
    check_eq("rst2_empty", {31'd0, empty}, 32'd1);
    send_byte(8'h75, 1'b0);
    check_head("mid_rst", 8'h75, 1'b0, 1'b0);
    pop_one();

`ifdef ASCII_LUT_EN
    send_byte(8'h12, 1'b0); send_byte(8'h1C, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'h12, 1'b0); send_byte(8'h1C, 1'b0);
    check_head("as0", 8'h12, 1'b0, 1'b0);
    check_eq("as0_ascii", {24'd0, ascii}, 32'h00); pop_one();
    check_head("as1", 8'h1C, 1'b0, 1'b0);
    check_eq("as1_ascii", {24'd0, ascii}, 32'h41); pop_one();
    check_head("as2", 8'h12, 1'b0, 1'b1);
    check_eq("as2_ascii", {24'd0, ascii}, 32'h00); pop_one();
    check_head("as3", 8'h1C, 1'b0, 1'b0);
    check_eq("as3_ascii", {24'd0, ascii}, 32'h61); pop_one();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
